// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - parametrised one-hot serial pattern detector; optional state check under SEQ_DETECT_STATE_CHK_EN
module seq_detect_fsm #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 din,
  input  logic                 din_vld,
  input  logic                 overlap,
  output logic                 dout,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [PATTERN_W:0]   state,
  output logic                 err
);

  localparam int               ST_W    = PATTERN_W + 1;
  localparam logic [ST_W-1:0]  IDLE    = ST_W'(1);
  localparam logic [ST_W-1:0]  ST0     = ST_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Pattern bit i counted from the first bit received (the MSB).
  function automatic logic pat_bit(input int i);
    logic [PATTERN_W-1:0] t;
    t = PATTERN >> (PATTERN_W - 1 - i);
    return t[0];
  endfunction

  // Longest proper pattern prefix that is a suffix of (first k pattern bits + b).
  // Capped below PATTERN_W so a completed match falls back to the prefix-suffix.
  function automatic int kmp_next(input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    for (int j = 1; j < PATTERN_W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          idx = k + 1 - j + i;
          sb  = (idx == k) ? b : pat_bit(idx);
          if (sb != pat_bit(i)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  logic [ST_W-1:0]      nxt0_oh [PATTERN_W];
  logic [ST_W-1:0]      nxt1_oh [PATTERN_W];
  logic [PATTERN_W-1:0] act;
  logic [ST_W-1:0]      state_n;
  logic                 hit;
  logic                 bad;

  // Elaboration-time transition table; IDLE behaves exactly like ST[0].
  for (genvar g = 0; g < PATTERN_W; g++) begin : g_tbl
    localparam int N0 = kmp_next(g, 1'b0);
    localparam int N1 = kmp_next(g, 1'b1);
    assign nxt0_oh[g] = ST_W'(1) << (N0 + 1);
    assign nxt1_oh[g] = ST_W'(1) << (N1 + 1);
    if (g == 0) begin : g_first
      assign act[g] = state[0] | state[1];
    end else begin : g_rest
      assign act[g] = state[g+1];
    end
  end

  // Next-state and match decision for the qualified input bit.
  always_comb begin
    state_n = state;
    hit     = 1'b0;
    if (din_vld) begin
      state_n = '0;
      for (int k = 0; k < PATTERN_W; k++) begin
        if (act[k]) state_n = state_n | (din ? nxt1_oh[k] : nxt0_oh[k]);
      end
      if (act[PATTERN_W-1] && (din == PATTERN[0])) begin
        hit = 1'b1;
        if (!overlap) state_n = ST0;
      end
    end
  end

`ifdef SEQ_DETECT_STATE_CHK_EN
  assign bad = !$onehot(state);
`else
  assign bad = 1'b0;
`endif

  // State register, registered match strobe and saturating match counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dout      <= 1'b0;
      match_cnt <= '0;
    end else if (clr) begin
      state     <= IDLE;
      dout      <= 1'b0;
      match_cnt <= '0;
    end else if (bad) begin
      state     <= IDLE;
      dout      <= 1'b0;
    end else begin
      state <= state_n;
      dout  <= hit;
      if (hit && (match_cnt != CNT_MAX)) match_cnt <= match_cnt + 1'b1;
    end
  end

`ifdef SEQ_DETECT_STATE_CHK_EN
  // Sticky illegal-state flag, cleared only by reset or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    err <= 1'b0;
    else if (clr)  err <= 1'b0;
    else if (bad)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
